// File: rtl/obi_err_sub.sv
// OBI error subordinate. It sits behind unmapped address ranges, grants
// requests, answers each one in order with err=1, and holds the first
// faulting address for software to read.

package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
    logic        UseRReady;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: 32,
    DataWidth: 32,
    IdWidth:   4,
    UseRReady: 1'b0
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module obi_err_sub #(
  parameter obi_pkg::obi_cfg_t ObiCfg      = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t   = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t   = obi_pkg::obi_rsp_t,
  parameter int unsigned       NumMaxTrans = 1,
  parameter logic [31:0]       RspData     = 32'hBADCAB1E
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  obi_req_t                    obi_req_i,
  output obi_rsp_t                    obi_rsp_o,
  output logic                        err_valid_o,
  output logic [ObiCfg.AddrWidth-1:0] err_addr_o,
  output logic                        err_we_o,
  input  logic                        err_clr_i
);

  localparam int unsigned AddrWidth = ObiCfg.AddrWidth;
  localparam int unsigned DataWidth = ObiCfg.DataWidth;
  localparam int unsigned IdWidth   = ObiCfg.IdWidth;
  localparam int unsigned IdW       = (IdWidth == 0) ? 1 : IdWidth;
  localparam int unsigned PtrW      = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned CntW      = $clog2(NumMaxTrans + 1);
  localparam int unsigned Slots     = 2 ** PtrW;

  // Storage is sized to the full pointer range so indexing is exact-width;
  // the pointers themselves only ever visit 0..NumMaxTrans-1.
  logic [IdW-1:0]  fifo_q [Slots];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic full, empty, gnt, rvalid, rready_eff, push, pop;

  logic                 err_valid_q;
  logic [AddrWidth-1:0] err_addr_q;
  logic                 err_we_q;

  logic unused_bits;
  assign unused_bits = ^{obi_req_i.a.be, obi_req_i.a.wdata};

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(NumMaxTrans - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Grant/response handshake decode and response payload; both channels are
  // held quiet while reset is asserted.
  always_comb begin
    full       = (count_q == CntW'(NumMaxTrans));
    empty      = (count_q == '0);
    gnt        = obi_req_i.req && !full && rst_ni;
    rvalid     = !empty && rst_ni;
    rready_eff = ObiCfg.UseRReady ? obi_req_i.rready : 1'b1;
    push       = gnt;
    pop        = rvalid && rready_eff;

    obi_rsp_o         = '0;
    obi_rsp_o.gnt     = gnt;
    obi_rsp_o.rvalid  = rvalid;
    obi_rsp_o.r.rdata = DataWidth'(RspData);
    obi_rsp_o.r.rid   = IdWidth'(fifo_q[rd_ptr_q]);
    obi_rsp_o.r.err   = 1'b1;
  end

  // ID storage is plain data; validity comes from the count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= IdW'(obi_req_i.a.aid);
    end
  end

  // FIFO pointers and occupancy; reset drops every outstanding ID.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // First-fault capture; a clear always wins over a simultaneous handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || err_clr_i) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_we_q    <= 1'b0;
    end else if (push && !err_valid_q) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= AddrWidth'(obi_req_i.a.addr);
      err_we_q    <= obi_req_i.a.we;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_we_o    = err_we_q;

`ifndef SYNTHESIS
  logic           stall_q;
  logic [IdW-1:0] prev_rid_q;

  // Remember a stalled response so its stability can be checked next cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q    <= 1'b0;
      prev_rid_q <= '0;
    end else begin
      stall_q    <= rvalid && !rready_eff;
      prev_rid_q <= fifo_q[rd_ptr_q];
    end
  end

  // FIFO overflow/underflow and response-hold sanity checks.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(pop && empty));
      assert (!(push && full));
      if (stall_q) begin
        assert (rvalid && (fifo_q[rd_ptr_q] == prev_rid_q));
      end
    end
  end
`endif

endmodule

// File: tb/tb_obi_err_sub.sv
// Directed bench for obi_err_sub: three instances cover UseRReady off/on
// and FIFO depths 2 and 3, with hand-computed expected responses.

module tb_obi_err_sub;

  localparam obi_pkg::obi_cfg_t CfgNoRr = obi_pkg::ObiDefaultConfig;
  localparam obi_pkg::obi_cfg_t CfgRr   = '{
    AddrWidth: 32,
    DataWidth: 32,
    IdWidth:   4,
    UseRReady: 1'b1
  };

  logic clk = 1'b0;
  logic rst_n;

  obi_pkg::obi_req_t req_v     [3];
  obi_pkg::obi_rsp_t rsp_v     [3];
  logic              err_clr   [3];
  logic              err_valid [3];
  logic [31:0]       err_addr  [3];
  logic              err_we    [3];

  int checks;
  int passes;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  obi_err_sub #(.ObiCfg(CfgNoRr), .NumMaxTrans(2)) u_norr2 (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_v[0]), .obi_rsp_o(rsp_v[0]),
    .err_valid_o(err_valid[0]), .err_addr_o(err_addr[0]), .err_we_o(err_we[0]),
    .err_clr_i(err_clr[0])
  );

  obi_err_sub #(.ObiCfg(CfgRr), .NumMaxTrans(2)) u_rr2 (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_v[1]), .obi_rsp_o(rsp_v[1]),
    .err_valid_o(err_valid[1]), .err_addr_o(err_addr[1]), .err_we_o(err_we[1]),
    .err_clr_i(err_clr[1])
  );

  obi_err_sub #(.ObiCfg(CfgRr), .NumMaxTrans(3)) u_rr3 (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_v[2]), .obi_rsp_o(rsp_v[2]),
    .err_valid_o(err_valid[2]), .err_addr_o(err_addr[2]), .err_we_o(err_we[2]),
    .err_clr_i(err_clr[2])
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic r, input logic [31:0] addr,
                               input logic we, input logic [3:0] aid,
                               input logic rready, input logic clr);
    req_v[idx]        = '0;
    req_v[idx].req    = r;
    req_v[idx].a.addr = addr;
    req_v[idx].a.we   = we;
    req_v[idx].a.aid  = aid;
    req_v[idx].rready = rready;
    err_clr[idx]      = clr;
    #1;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    end
    applyStimulus(0, 1'b1, 32'h1234_0000, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state, with req held high to show grant stays low.
    checkOutput("rst_gnt", rsp_v[0].gnt, 0);
    checkOutput("rst_rvalid", rsp_v[0].rvalid, 0);
    checkOutput("rst_err_valid", err_valid[0], 0);
    checkOutput("rst_err_addr", err_addr[0], 0);
    checkOutput("rst_err_we", err_we[0], 0);

    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();

    // Capture register: first write captured, read ignored, clear wins.
    applyStimulus(0, 1'b1, 32'h4000_0010, 1'b1, 4'd1, 1'b0, 1'b0);
    checkOutput("cap_gnt_w", rsp_v[0].gnt, 1);
    checkOutput("cap_idle", err_valid[0], 0);
    tick();
    applyStimulus(0, 1'b1, 32'h5000_0000, 1'b0, 4'd2, 1'b0, 1'b0);
    checkOutput("cap_gnt_r", rsp_v[0].gnt, 1);
    checkOutput("cap_rid1", rsp_v[0].r.rid, 1);
    checkOutput("cap_valid", err_valid[0], 1);
    checkOutput("cap_addr", err_addr[0], 32'h4000_0010);
    checkOutput("cap_we", err_we[0], 1);
    tick();
    applyStimulus(0, 1'b1, 32'h6000_0000, 1'b0, 4'd3, 1'b0, 1'b1);
    checkOutput("cap_hold_valid", err_valid[0], 1);
    checkOutput("cap_hold_addr", err_addr[0], 32'h4000_0010);
    checkOutput("cap_hold_we", err_we[0], 1);
    checkOutput("cap_rid2", rsp_v[0].r.rid, 2);
    tick();
    applyStimulus(0, 1'b1, 32'h7000_0000, 1'b0, 4'd4, 1'b0, 1'b0);
    checkOutput("clr_wins", err_valid[0], 0);
    checkOutput("cap_rid3", rsp_v[0].r.rid, 3);
    tick();
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("rearm_valid", err_valid[0], 1);
    checkOutput("rearm_addr", err_addr[0], 32'h7000_0000);
    checkOutput("rearm_we", err_we[0], 0);
    tick();
    tick();

    // Single read with latency-one error response.
    applyStimulus(0, 1'b1, 32'h5000_0000, 1'b0, 4'd3, 1'b0, 1'b0);
    checkOutput("rd_gnt", rsp_v[0].gnt, 1);
    checkOutput("rd_no_fallthru", rsp_v[0].rvalid, 0);
    tick();
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("rd_rvalid", rsp_v[0].rvalid, 1);
    checkOutput("rd_rid", rsp_v[0].r.rid, 3);
    checkOutput("rd_err", rsp_v[0].r.err, 1);
    checkOutput("rd_rdata", rsp_v[0].r.rdata, 32'hBADCAB1E);
    tick();
    checkOutput("rd_done", rsp_v[0].rvalid, 0);

    // Back-pressure: depth 2 fills, third request waits, order preserved.
    applyStimulus(1, 1'b1, 32'h9000_0000, 1'b0, 4'd1, 1'b0, 1'b0);
    checkOutput("bp_gnt1", rsp_v[1].gnt, 1);
    tick();
    applyStimulus(1, 1'b1, 32'h9000_0004, 1'b0, 4'd2, 1'b0, 1'b0);
    checkOutput("bp_gnt2", rsp_v[1].gnt, 1);
    checkOutput("bp_rid1_a", rsp_v[1].r.rid, 1);
    tick();
    applyStimulus(1, 1'b1, 32'h9000_0008, 1'b0, 4'd3, 1'b0, 1'b0);
    checkOutput("bp_full_gnt", rsp_v[1].gnt, 0);
    checkOutput("bp_rvalid", rsp_v[1].rvalid, 1);
    checkOutput("bp_rid1_b", rsp_v[1].r.rid, 1);
    tick();
    checkOutput("bp_rid1_c", rsp_v[1].r.rid, 1);
    applyStimulus(1, 1'b1, 32'h9000_0008, 1'b0, 4'd3, 1'b1, 1'b0);
    checkOutput("bp_full_pop_gnt", rsp_v[1].gnt, 0);
    tick();
    applyStimulus(1, 1'b1, 32'h9000_0008, 1'b0, 4'd3, 1'b1, 1'b0);
    checkOutput("bp_gnt3", rsp_v[1].gnt, 1);
    checkOutput("bp_rid2", rsp_v[1].r.rid, 2);
    tick();
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("bp_rvalid3", rsp_v[1].rvalid, 1);
    checkOutput("bp_rid3", rsp_v[1].r.rid, 3);
    tick();
    checkOutput("bp_drained", rsp_v[1].rvalid, 0);

    // Streaming through depth 3: pointers wrap twice, IDs return in order.
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        applyStimulus(2, 1'b1, 32'hA000_0000 + 32'(i * 4), 1'b0, 4'(i), 1'b1, 1'b0);
        checkOutput($sformatf("st_gnt%0d", i), rsp_v[2].gnt, 1);
      end else begin
        applyStimulus(2, 1'b0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
      end
      if (i > 0) begin
        checkOutput($sformatf("st_rvalid%0d", i - 1), rsp_v[2].rvalid, 1);
        checkOutput($sformatf("st_rid%0d", i - 1), rsp_v[2].r.rid, 64'(i - 1));
      end else begin
        checkOutput("st_first_idle", rsp_v[2].rvalid, 0);
      end
      tick();
    end
    checkOutput("st_drained", rsp_v[2].rvalid, 0);

    // Reset with two IDs outstanding flushes them.
    applyStimulus(1, 1'b1, 32'h8000_0000, 1'b0, 4'd6, 1'b0, 1'b0);
    checkOutput("fl_gnt6", rsp_v[1].gnt, 1);
    tick();
    applyStimulus(1, 1'b1, 32'h8000_0004, 1'b0, 4'd7, 1'b0, 1'b0);
    checkOutput("fl_gnt7", rsp_v[1].gnt, 1);
    tick();
    rst_n = 1'b0;
    applyStimulus(1, 1'b1, 32'h8000_0008, 1'b0, 4'd9, 1'b0, 1'b0);
    checkOutput("fl_rst_gnt_now", rsp_v[1].gnt, 0);
    tick();
    checkOutput("fl_rvalid", rsp_v[1].rvalid, 0);
    checkOutput("fl_gnt", rsp_v[1].gnt, 0);
    checkOutput("fl_err_valid1", err_valid[1], 0);
    checkOutput("fl_err_valid0", err_valid[0], 0);
    rst_n = 1'b1;
    applyStimulus(1, 1'b1, 32'h8000_0010, 1'b0, 4'd5, 1'b1, 1'b0);
    checkOutput("fl_gnt5", rsp_v[1].gnt, 1);
    checkOutput("fl_empty", rsp_v[1].rvalid, 0);
    tick();
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("fl_rvalid5", rsp_v[1].rvalid, 1);
    checkOutput("fl_rid5", rsp_v[1].r.rid, 5);
    tick();
    checkOutput("fl_done", rsp_v[1].rvalid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/obi_err_sub.md
Name: obi_err_sub

Overview:
- OBI subordinate that terminates every request it receives with an error response.
- Attached to a crossbar manager port that the address map selects as default, or by rule, for unmapped ranges. Managers that access holes in the map therefore get `err=1` instead of hanging.
- Tracks up to NumMaxTrans outstanding transactions in order, returning each one's `aid` as `rid`.
- Captures the first faulting address for software diagnosis.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration. Provides AddrWidth, DataWidth, IdWidth, UseRReady.
- obi_req_t, logic, OBI request struct (`req`, `a.addr`, `a.we`, `a.aid`, optional `rready`).
- obi_rsp_t, logic, OBI response struct (`gnt`, `rvalid`, `r.rdata`, `r.rid`, `r.err`).
- NumMaxTrans, 1, depth of the outstanding-transaction ID FIFO. Must be >= 1.
- RspData, 32'hBADCAB1E, value driven on `r.rdata`. Zero-extended or truncated to DataWidth.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, synchronous, active-low.
- obi_req_i  input  obi_req_t  request from the crossbar manager port.
- obi_rsp_o  output  obi_rsp_t  response to the crossbar.
- err_valid_o  output  1  high while a captured error is held.
- err_addr_o  output  AddrWidth  address of the first captured faulting request.
- err_we_o  output  1  `we` of the captured request.
- err_clr_i  input  1  clears the capture register and re-arms it.

Behaviour:
- Reset: the only reset is synchronous. It is sampled at a clk_i rising edge with rst_ni=0.
  - FIFO empties; read/write pointers and count go to 0.
  - `gnt`=0 and `rvalid`=0 in the cycle after reset is sampled, and for as long as it is held.
  - `err_valid_o`=0, `err_addr_o`=0, `err_we_o`=0.
- Reset mid-operation discards all outstanding IDs. No response is emitted for them.
- ID FIFO: depth NumMaxTrans, width IdWidth (1 when IdWidth=0). count ranges 0..NumMaxTrans.
  - full = (count==NumMaxTrans); empty = (count==0).
  - Pointers wrap from NumMaxTrans-1 to 0. This must be correct for non-power-of-two depths.
- Grant: `gnt` = `req` && !full. This is combinational, with no fall-through.
  - When full, `gnt`=0 even if a pop happens in the same cycle.
  - A handshake is `req`&&`gnt`. It pushes `a.aid` into the FIFO.
- Response:
  - `rvalid` = !empty. Earliest `rvalid` is the cycle after the handshake (latency 1), and only from the registered FIFO state.
  - `r.rid` = FIFO head; `r.err`=1 always; `r.rdata`=RspData for both reads and writes.
  - Other r-channel optional fields are driven to 0.
- Response acceptance: pop = `rvalid` && (`rready` if UseRReady, else 1).
  - With UseRReady, `rvalid`, `rid`, `rdata` and `err` are held stable until accepted.
- Simultaneous push and pop with count unchanged (not full): the head advances and the new ID is written at the tail. Order is strict FIFO.
- Capture register:
  - It loads `a.addr`/`a.we` on a handshake when `err_valid_o`=0 and sets `err_valid_o` the next cycle.
  - Later handshakes do not overwrite it while `err_valid_o`=1.
  - `err_clr_i`=1 clears `err_valid_o` the next cycle.
  - `err_clr_i` in the same cycle as a handshake: clear wins, the new request is not captured, and the register is re-armed for the next handshake.
- `req` deasserted while `gnt`=0 is tolerated (no protocol check). `a.*` is sampled only on a handshake.
- Assertions, simulation only:
  - no pop when empty;
  - no push when full;
  - with UseRReady, the response must stay stable while `rvalid`&&!`rready`.

Test Plan:
1. Reset, then a single read with `aid`=3 (NumMaxTrans=2, UseRReady=0).
   - `gnt`=1 in the request cycle.
   - Next cycle: `rvalid`=1, `rid`=3, `err`=1, `rdata`=32'hBADCAB1E; `rvalid`=0 the cycle after.
2. Back-to-back requests, `aid`=1,2,3, with `rready`=0 held (UseRReady=1, NumMaxTrans=2).
   - Grants for aid 1 and 2.
   - aid 3 sees `gnt`=0 while count=2. Responses are held at `rid`=1.
   - Raise `rready`: `rid`=1, 2, then 3 is granted and returned in order.
3. NumMaxTrans=3, 7 requests streaming with `rready`=1.
   - `rid` sequence equals `aid` sequence 0..6, with no gaps.
   - Pointers wrap twice and count never exceeds 1.
4. Write to addr 32'h4000_0010, then a read to 32'h5000_0000.
   - `err_valid_o`=1, `err_addr_o`=32'h4000_0010, `err_we_o`=1, unchanged by the read.
   - `err_clr_i` pulse with the next request at 32'h6000_0000 in the same cycle: `err_valid_o`=0, still 0 for that request.
   - A following request at 32'h7000_0000 is captured.
5. Reset asserted with 2 transactions outstanding.
   - Next cycle: `rvalid`=0, `gnt`=0, `err_valid_o`=0.
   - After release, a new request with `aid`=5 returns `rid`=5, proving the stale IDs are flushed.
